fighter_guard_fsm: RTL and testbench

Parametrised guard/health controller for one Punch-Out fighter, user or enemy. It replaces the single-use block/health FSM. Incoming punches arrive on N_PUNCH priority-ordered channels, each carrying its own damage. The block owns the health register, applies saturating damage, and enforces a timed stun/draw window after each hit, a guard fatigue timeout and a latched KO, giving the renderer and opponent logic clean status outputs.

---
 rtl/fighter_guard_fsm.sv | 118 +++++++++++
 tb/tb_fighter_guard_fsm.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fighter_guard_fsm.sv
// Guard/health controller for one fighter: prioritised punch intake, saturating
// health, timed stun window, guard fatigue timeout and a latched KO.
module fighter_guard_fsm #(
  parameter int HEALTH_W    = 4,
  parameter int MAX_HEALTH  = 15,
  parameter int N_PUNCH     = 2,
  parameter int DAMAGE_W    = 3,
  parameter int STUN_CYCLES = 4,
  parameter int GUARD_MAX   = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         block,
  input  logic [N_PUNCH-1:0]           hit_valid,
  input  logic [N_PUNCH*DAMAGE_W-1:0]  hit_damage,
  output logic [HEALTH_W-1:0]          health,
  output logic                         can_be_hit,
  output logic                         blocking,
  output logic                         plot,
  output logic                         dead,
  output logic                         hit_taken,
  output logic                         hit_blocked
);

  // state  | meaning
  // IDLE   | open to hits, may raise guard
  // GUARD  | hits absorbed, fatigue timer running
  // STUN   | hit sprite shown, inputs ignored
  // DEAD   | KO latched until reset
  typedef enum logic [1:0] {IDLE, GUARD, STUN, DEAD} state_t;

  localparam int CNT_MAX = (STUN_CYCLES > GUARD_MAX) ? STUN_CYCLES : GUARD_MAX;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = (HEALTH_W > DAMAGE_W) ? HEALTH_W : DAMAGE_W;

  state_t              state_q, state_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                hit_taken_q, hit_taken_d;
  logic                hit_blocked_q, hit_blocked_d;

  logic                any_hit;
  logic [DAMAGE_W-1:0] sel_dmg;
  logic [DW-1:0]       h_ext, d_ext;
  logic [HEALTH_W-1:0] health_after;
  logic                stun_done, guard_done;

  // Descending scan so the lowest-index valid channel is the last to assign.
  always_comb begin
    sel_dmg = '0;
    for (int i = N_PUNCH - 1; i >= 0; i--) begin
      if (hit_valid[i]) sel_dmg = hit_damage[i*DAMAGE_W +: DAMAGE_W];
    end
  end

  assign any_hit      = |hit_valid;
  assign h_ext        = DW'(health_q);
  assign d_ext        = DW'(sel_dmg);
  assign health_after = (h_ext > d_ext) ? HEALTH_W'(h_ext - d_ext) : '0;
  assign stun_done    = (cnt_q == CW'(STUN_CYCLES - 1));
  assign guard_done   = (GUARD_MAX > 0) && (cnt_q == CW'(GUARD_MAX - 1));

  always_comb begin
    state_d       = state_q;
    health_d      = health_q;
    hit_taken_d   = 1'b0;
    hit_blocked_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_hit) begin
          health_d    = health_after;
          hit_taken_d = 1'b1;
          state_d     = (health_after == '0) ? DEAD : STUN;
        end else if (block) begin
          state_d = GUARD;
        end
      end
      GUARD: begin
        hit_blocked_d = any_hit;
        if (block || guard_done) state_d = IDLE;
      end
      STUN: begin
        if (stun_done) state_d = IDLE;
      end
      default: state_d = DEAD;
    endcase

    // Counter restarts on every state change so each window times from its entry edge.
    if (state_d != state_q) cnt_d = '0;
    else if (state_q == STUN || state_q == GUARD) cnt_d = cnt_q + 1'b1;
    else cnt_d = cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      health_q      <= HEALTH_W'(MAX_HEALTH);
      cnt_q         <= '0;
      hit_taken_q   <= 1'b0;
      hit_blocked_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      health_q      <= health_d;
      cnt_q         <= cnt_d;
      hit_taken_q   <= hit_taken_d;
      hit_blocked_q <= hit_blocked_d;
    end
  end

  assign health      = health_q;
  assign can_be_hit  = (state_q == IDLE);
  assign blocking    = (state_q == GUARD);
  assign plot        = (state_q == STUN);
  assign dead        = (state_q == DEAD);
  assign hit_taken   = hit_taken_q;
  assign hit_blocked = hit_blocked_q;

endmodule

// File: tb/tb_fighter_guard_fsm.sv
// Directed bench for fighter_guard_fsm: each step queues the expected post-edge
// outputs, then pops and checks them one cycle later.
module tb_fighter_guard_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       block = 1'b0;
  logic [1:0] hit_valid = '0;
  logic [5:0] hit_damage = '0;
  logic [3:0] health;
  logic       can_be_hit, blocking, plot, dead, hit_taken, hit_blocked;
  logic [5:0] status;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [5:0] S_IDLE  = 6'b100000;
  localparam logic [5:0] S_GUARD = 6'b010000;
  localparam logic [5:0] S_STUN  = 6'b001000;
  localparam logic [5:0] S_DEAD  = 6'b000100;
  localparam logic [5:0] P_HT    = 6'b000010;
  localparam logic [5:0] P_HB    = 6'b000001;

  typedef struct {
    string      tag;
    logic [3:0] h;
    logic [5:0] st;
  } exp_t;

  exp_t sb[$];

  fighter_guard_fsm dut (
    .clock      (clock),
    .reset      (reset),
    .block      (block),
    .hit_valid  (hit_valid),
    .hit_damage (hit_damage),
    .health     (health),
    .can_be_hit (can_be_hit),
    .blocking   (blocking),
    .plot       (plot),
    .dead       (dead),
    .hit_taken  (hit_taken),
    .hit_blocked(hit_blocked)
  );

  always #5 clock = ~clock;

  assign status = {can_be_hit, blocking, plot, dead, hit_taken, hit_blocked};

  task automatic cyc(input string tag, input logic rst, input logic blk,
                     input logic [1:0] hv, input logic [5:0] hd,
                     input logic [3:0] eh, input logic [5:0] est);
    exp_t e;
    exp_t got;
    @(negedge clock);
    reset      = rst;
    block      = blk;
    hit_valid  = hv;
    hit_damage = hd;
    e.tag = tag;
    e.h   = eh;
    e.st  = est;
    sb.push_back(e);
    @(posedge clock);
    #1;
    got = sb.pop_front();
    n_vec++;
    assert (health === got.h) else begin
      n_err++;
      $error("FAIL %s health: got %0d want %0d", got.tag, health, got.h);
    end
    n_vec++;
    assert (status === got.st) else begin
      n_err++;
      $error("FAIL %s status{cbh,blk,plot,dead,ht,hb}: got %b want %b", got.tag, status, got.st);
    end
  endtask

  task automatic idle(input string tag, input int n, input logic [3:0] eh, input logic [5:0] est);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 2'b00, 6'h00, eh, est);
  endtask

  initial begin
    // reset and quiet idle
    cyc("reset0", 1'b1, 1'b0, 2'b00, 6'h00, 4'd15, S_IDLE);
    cyc("reset1", 1'b1, 1'b0, 2'b00, 6'h00, 4'd15, S_IDLE);
    idle("idle_hold", 10, 4'd15, S_IDLE);

    // landed hit ch0=3, stun for exactly 4 cycles
    cyc("hit_ch0", 1'b0, 1'b0, 2'b01, 6'h03, 4'd12, S_STUN | P_HT);
    idle("stun_hold", 3, 4'd12, S_STUN);
    idle("stun_exit", 1, 4'd12, S_IDLE);

    // both channels plus block: ch0 (1) wins, block discarded
    cyc("prio_blk", 1'b0, 1'b1, 2'b11, 6'h29, 4'd11, S_STUN | P_HT);
    idle("prio_stun", 1, 4'd11, S_STUN);
    cyc("stun_ign", 1'b0, 1'b1, 2'b01, 6'h07, 4'd11, S_STUN);
    idle("prio_stun2", 1, 4'd11, S_STUN);
    cyc("hit_at_exit", 1'b0, 1'b0, 2'b01, 6'h07, 4'd11, S_IDLE);

    // guard absorb, consecutive pulses, fatigue at 16 cycles
    cyc("guard_on", 1'b0, 1'b1, 2'b00, 6'h00, 4'd11, S_GUARD);
    cyc("guard_ch1", 1'b0, 1'b0, 2'b10, 6'h38, 4'd11, S_GUARD | P_HB);
    cyc("guard_ch0", 1'b0, 1'b0, 2'b01, 6'h07, 4'd11, S_GUARD | P_HB);
    idle("guard_hold", 13, 4'd11, S_GUARD);
    idle("fatigue", 1, 4'd11, S_IDLE);
    idle("post_fatigue", 1, 4'd11, S_IDLE);

    // block+hit in guard leaves guard with one absorb pulse
    cyc("guard_on2", 1'b0, 1'b1, 2'b00, 6'h00, 4'd11, S_GUARD);
    cyc("guard_off_hit", 1'b0, 1'b1, 2'b01, 6'h07, 4'd11, S_IDLE | P_HB);
    idle("pulse_once", 1, 4'd11, S_IDLE);

    // toggle on the timeout edge: one exit, no re-entry
    cyc("guard_on3", 1'b0, 1'b1, 2'b00, 6'h00, 4'd11, S_GUARD);
    idle("guard_hold3", 15, 4'd11, S_GUARD);
    cyc("toggle_at_to", 1'b0, 1'b1, 2'b00, 6'h00, 4'd11, S_IDLE);
    idle("no_double", 1, 4'd11, S_IDLE);

    // walk health down to 2, then KO with saturation
    cyc("dmg7", 1'b0, 1'b0, 2'b01, 6'h07, 4'd4, S_STUN | P_HT);
    idle("stun_a", 3, 4'd4, S_STUN);
    idle("idle_a", 1, 4'd4, S_IDLE);
    cyc("dmg2_ch1", 1'b0, 1'b0, 2'b10, 6'h10, 4'd2, S_STUN | P_HT);
    idle("stun_b", 3, 4'd2, S_STUN);
    idle("idle_b", 1, 4'd2, S_IDLE);
    cyc("ko", 1'b0, 1'b0, 2'b01, 6'h07, 4'd0, S_DEAD | P_HT);
    cyc("dead_hit", 1'b0, 1'b1, 2'b11, 6'h3F, 4'd0, S_DEAD);
    cyc("dead_blk", 1'b0, 1'b1, 2'b00, 6'h00, 4'd0, S_DEAD);
    idle("dead_hold", 3, 4'd0, S_DEAD);
    cyc("ko_reset", 1'b1, 1'b0, 2'b00, 6'h00, 4'd15, S_IDLE);

    // zero-damage hit still stuns
    cyc("dmg0", 1'b0, 1'b0, 2'b01, 6'h00, 4'd15, S_STUN | P_HT);
    idle("stun_c", 3, 4'd15, S_STUN);
    idle("idle_c", 1, 4'd15, S_IDLE);

    // reset two cycles into stun
    cyc("hit_pre_rst", 1'b0, 1'b0, 2'b01, 6'h03, 4'd12, S_STUN | P_HT);
    idle("stun_d", 1, 4'd12, S_STUN);
    cyc("rst_mid_stun", 1'b1, 1'b0, 2'b00, 6'h00, 4'd15, S_IDLE);
    idle("after_rst", 1, 4'd15, S_IDLE);

    // reset mid-guard discards the fatigue count
    cyc("guard_on4", 1'b0, 1'b1, 2'b00, 6'h00, 4'd15, S_GUARD);
    idle("guard_hold4", 5, 4'd15, S_GUARD);
    cyc("rst_mid_guard", 1'b1, 1'b1, 2'b01, 6'h07, 4'd15, S_IDLE);
    cyc("guard_on5", 1'b0, 1'b1, 2'b00, 6'h00, 4'd15, S_GUARD);
    idle("guard_hold5", 15, 4'd15, S_GUARD);
    idle("fatigue5", 1, 4'd15, S_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
